argmax_layer: RTL
=================

Name: argmax_layer

Overview:
- Sequential classifier stage directly downstream of the final dense layer.
- Captures the layer's NUM_INPUTS fixed-point outputs when they become ready, then scans them one per cycle for the maximum.
- Reports the winning index and its value with a ready flag.
- Gives the network its class decision without a NUM_INPUTS-wide combinational compare tree.

Parameters:
- NUM_INPUTS, default 10: number of values to compare (neurons in the upstream layer); legal range ≥ 2.
- INDEX_WIDTH, default $clog2(NUM_INPUTS): width of the index output; derived, never overridden.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- inputs_ready  input  1  level from upstream (its outputs_ready); a rising edge starts a scan.
- inputs  input  signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] x NUM_INPUTS  upstream layer outputs.
- index  output  INDEX_WIDTH  position of the maximum value.
- max_value  output  signed [INTEGER_WIDTH-1:-FRACTION_WIDTH]  the maximum value itself.
- output_ready  output  1  high while index/max_value hold a valid result.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, index=0, max_value=0, output_ready=0, scan counter=0, capture buffer cleared, inputs_ready edge register=0.
- Edge detect: start = inputs_ready & ~inputs_ready_q, with inputs_ready_q registered every cycle. A level held high does not retrigger.
- States: IDLE, SCAN, DONE.
- IDLE or DONE, start=1:
  - Copy all inputs into the capture buffer.
  - Load running max = inputs[0], running index = 0, counter = 1.
  - Drop output_ready to 0 on the same edge; go to SCAN.
- SCAN, each cycle compare buffer[counter] with running max (signed, full width):
  - Strictly greater replaces max and index. Ties keep the lower index.
  - If counter == NUM_INPUTS-1: write the final max/index to max_value/index, set output_ready=1, go to DONE.
  - Otherwise counter+1.
- Latency: from the cycle start is sampled high to output_ready high is exactly NUM_INPUTS cycles (1 capture + NUM_INPUTS-1 compares).
- DONE: outputs and output_ready hold until the next start or reset.
- start during SCAN: ignored. inputs_ready edges are not queued; the buffer isolates the scan from input changes.
- index and max_value change only on the cycle output_ready rises. They are never observed mid-scan.
- Arithmetic: compare only, no widening. Most-negative value (100…0) is handled correctly.
- Reset mid-SCAN: abort immediately to the reset values. A later rising edge of inputs_ready is needed to restart; a level already high at reset release counts as a rising edge, because inputs_ready_q resets to 0.

Decomposition:
- Shared package (include.svh): INTEGER_WIDTH, FRACTION_WIDTH, the fixed-point typedef for one value, and an argmax_state_t enum {IDLE, SCAN, DONE}.
- No sub-module needed. Capture buffer, counter, comparator and FSM fit in one module of about 150 lines.
- Optional: factor the edge detector into rising_edge_detector if another stage needs it.

Test Plan:
- Reset, then pulse inputs_ready with inputs={0.5,-1,3.25,2,0,0,0,0,0,1} -> exactly 10 cycles later output_ready=1, index=2, max_value=3.25.
- All inputs = -2.0 -> index=0, max_value=-2.0 (tie rule); a second test with equal maxima at positions 4 and 7 -> index=4.
- Maximum in the last position (inputs[9]=most-positive, others most-negative) -> index=9; checks the final-compare boundary and signed compare.
- Hold inputs_ready high for 30 cycles while changing inputs after capture -> exactly one scan, result matches the captured values, output_ready remains high; dropping and re-raising inputs_ready clears output_ready on the next edge and starts a new scan.
- Assert reset for 1 cycle at scan cycle 5 -> all outputs 0 asynchronously; inputs_ready held high through release -> new scan completes NUM_INPUTS cycles after release.
- Second rising edge of inputs_ready during SCAN -> ignored; result and timing equal to the undisturbed first scan.

Source files
------------

// File: rtl/argmax_layer_pkg.sv
// Shared fixed-point format and FSM encoding for the argmax classifier stage.
// Values are signed Q(INTEGER_WIDTH).(FRACTION_WIDTH); bit 0 of the range is the unit bit.
package argmax_layer_pkg;

  localparam int INTEGER_WIDTH  = 8;
  localparam int FRACTION_WIDTH = 8;
  localparam int VALUE_WIDTH    = INTEGER_WIDTH + FRACTION_WIDTH;

  typedef logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] fixed_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } argmax_state_t;

endpackage

// File: rtl/argmax_layer.sv
// Sequential argmax: captures NUM_INPUTS values on a rising edge of inputs_ready,
// then compares one buffered value per cycle against a running maximum.
module argmax_layer
  import argmax_layer_pkg::*;
#(
  parameter  int NUM_INPUTS  = 10,
  localparam int INDEX_WIDTH = $clog2(NUM_INPUTS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   inputs_ready,
  input  fixed_t                 inputs [NUM_INPUTS],
  output logic [INDEX_WIDTH-1:0] index,
  output fixed_t                 max_value,
  output logic                   output_ready,
  output argmax_state_t          state_dbg
);

  // Handshake: a rising edge of the inputs_ready level starts a scan (from IDLE or
  // DONE only; edges during SCAN are dropped, not queued). output_ready falls on the
  // capture edge and rises together with index/max_value after NUM_INPUTS cycles,
  // then holds until the next accepted start or reset.

  typedef logic [INDEX_WIDTH-1:0] idx_t;
  localparam idx_t LAST = idx_t'(NUM_INPUTS - 1);

  argmax_state_t state_q, state_d;
  logic          inputs_ready_q;
  logic          start;
  logic          capture;
  fixed_t        buffer_q [NUM_INPUTS];
  fixed_t        run_max_q, run_max_d;
  idx_t          run_idx_q, run_idx_d;
  idx_t          counter_q, counter_d;
  idx_t          index_d;
  fixed_t        max_value_d;
  logic          output_ready_d;
  fixed_t        candidate;
  logic          greater;

  assign start     = inputs_ready & ~inputs_ready_q;
  assign candidate = buffer_q[counter_q];
  // Strict signed compare: ties keep the earlier (lower) index.
  assign greater   = candidate > run_max_q;
  assign state_dbg = state_q;

  always_comb begin
    state_d        = state_q;
    run_max_d      = run_max_q;
    run_idx_d      = run_idx_q;
    counter_d      = counter_q;
    index_d        = index;
    max_value_d    = max_value;
    output_ready_d = output_ready;
    capture        = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          capture        = 1'b1;
          run_max_d      = inputs[0];
          run_idx_d      = '0;
          counter_d      = idx_t'(1);
          output_ready_d = 1'b0;
          state_d        = SCAN;
        end
      end
      SCAN: begin
        if (greater) begin
          run_max_d = candidate;
          run_idx_d = counter_q;
        end
        if (counter_q == LAST) begin
          max_value_d    = greater ? candidate : run_max_q;
          index_d        = greater ? counter_q : run_idx_q;
          output_ready_d = 1'b1;
          state_d        = DONE;
        end else begin
          counter_d = counter_q + idx_t'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      inputs_ready_q <= 1'b0;
      run_max_q      <= '0;
      run_idx_q      <= '0;
      counter_q      <= '0;
      index          <= '0;
      max_value      <= '0;
      output_ready   <= 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) buffer_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      inputs_ready_q <= inputs_ready;
      run_max_q      <= run_max_d;
      run_idx_q      <= run_idx_d;
      counter_q      <= counter_d;
      index          <= index_d;
      max_value      <= max_value_d;
      output_ready   <= output_ready_d;
      if (capture) buffer_q <= inputs;
    end
  end

endmodule
